burst_formatter: RTL and testbench



---
 rtl/burst_pkg.sv | 38 +++
 rtl/burst_formatter_if.sv | 18 +
 rtl/burst_formatter_strobe_edge.sv | 20 ++
 rtl/burst_formatter.sv | 165 ++++++++++++++++
 tb/tb_burst_formatter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_pkg.sv
// Shared burst layout constants, state encoding and training sequences
// for the normal-burst symbol path.
package burst_pkg;

    localparam int DEF_TAIL_LEN  = 3;
    localparam int DEF_HALF_LEN  = 58;
    localparam int DEF_TSC_LEN   = 26;
    localparam int DEF_GUARD_LEN = 8;
    localparam int BURST_SYMBOLS = 156;

    localparam logic [25:0] TSC_TABLE [8] = '{
        26'h0970897, 26'h0B778B7, 26'h10EE90E, 26'h11ED11E,
        26'h06B906B, 26'h13AC13A, 26'h29F629F, 26'h3BC4BBC
    };

    typedef enum logic [2:0] {
        IDLE,
        HEAD_TAIL,
        DATA_A,
        TRAIN,
        DATA_B,
        END_TAIL,
        GUARD
    } burst_state_e;

    function automatic burst_state_e next_state(burst_state_e s);
        unique case (s)
            IDLE:      return HEAD_TAIL;
            HEAD_TAIL: return DATA_A;
            DATA_A:    return TRAIN;
            TRAIN:     return DATA_B;
            DATA_B:    return END_TAIL;
            END_TAIL:  return GUARD;
            default:   return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/burst_formatter_if.sv
// Serial payload handshake between the bit source and the burst formatter.
interface burst_formatter_if;
    logic payload_bit;
    logic payload_valid;
    logic payload_ready;

    modport master (
        output payload_bit,
        output payload_valid,
        input  payload_ready
    );

    modport slave (
        input  payload_bit,
        input  payload_valid,
        output payload_ready
    );
endinterface

// File: rtl/burst_formatter_strobe_edge.sv
// Registered rising-edge detector for a symbol-rate strobe; one pulse
// per rise regardless of how long the strobe stays high.
module symbol_strobe_edge (
    input  logic clock,
    input  logic reset,
    input  logic strobe,
    output logic rise
);
    logic strobe_q;
    logic strobe_d;

    always_comb strobe_d = strobe;

    always_ff @(posedge clock) begin
        if (!reset) strobe_q <= 1'b0;
        else        strobe_q <= strobe_d;
    end

    assign rise = strobe & ~strobe_q;
endmodule

// File: rtl/burst_formatter.sv
// Normal-burst symbol source: tails, payload halves, midamble, guard.
// Differential encoding is enabled with BURST_FORMATTER_DIFF_ENCODE_EN.
module burst_formatter
    import burst_pkg::*;
#(
    parameter int          TAIL_LEN  = DEF_TAIL_LEN,
    parameter int          HALF_LEN  = DEF_HALF_LEN,
    parameter int          TSC_LEN   = DEF_TSC_LEN,
    parameter int          GUARD_LEN = DEF_GUARD_LEN,
    parameter logic [25:0] TSC       = 26'h0970897
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               next_symbol_strobe,
    input  logic               fire_burst,
    burst_formatter_if.slave   pay,
    output logic               current_symbol,
    output logic [7:0]         sym_index,
    output logic               busy,
    output logic               burst_done,
    output logic               underrun
);
    localparam logic [7:0] OFF_A = 8'(TAIL_LEN);
    localparam logic [7:0] OFF_T = 8'(TAIL_LEN + HALF_LEN);
    localparam logic [7:0] OFF_B = 8'(TAIL_LEN + HALF_LEN + TSC_LEN);
    localparam logic [7:0] OFF_E = 8'(TAIL_LEN + 2 * HALF_LEN + TSC_LEN);
    localparam logic [7:0] OFF_G = 8'(2 * TAIL_LEN + 2 * HALF_LEN + TSC_LEN);

    logic strobe_rise;

    symbol_strobe_edge u_edge (
        .clock  (clock),
        .reset  (reset),
        .strobe (next_symbol_strobe),
        .rise   (strobe_rise)
    );

    burst_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         current_symbol_q, current_symbol_d;
    logic [7:0]   sym_index_q, sym_index_d;
    logic         busy_q, busy_d;
    logic         burst_done_q, burst_done_d;
    logic         underrun_q, underrun_d;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
    logic         prev_sym_q, prev_sym_d;
`endif

    logic             b;
    logic [7:0]       base;
    logic [7:0]       len_m1;
    logic [TSC_LEN-1:0] tsc_sh;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        current_symbol_d = current_symbol_q;
        sym_index_d      = sym_index_q;
        busy_d           = busy_q;
        burst_done_d     = 1'b0;
        underrun_d       = underrun_q;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
        prev_sym_d       = prev_sym_q;
`endif
        pay.payload_ready = 1'b0;
        b                 = 1'b0;
        base              = 8'd0;
        len_m1            = 8'd0;
        tsc_sh            = TSC[TSC_LEN-1:0] << cnt_q;

        unique case (state_q)
            IDLE: begin
                current_symbol_d = 1'b1;
                sym_index_d      = 8'd0;
                busy_d           = 1'b0;
                cnt_d            = 8'd0;
                if (fire_burst) begin
                    state_d    = HEAD_TAIL;
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
                    prev_sym_d = 1'b1;
`endif
                end
            end
            HEAD_TAIL: begin
                len_m1 = 8'(TAIL_LEN - 1);
            end
            DATA_A, DATA_B: begin
                base   = (state_q == DATA_A) ? OFF_A : OFF_B;
                len_m1 = 8'(HALF_LEN - 1);
                pay.payload_ready = strobe_rise;
                b = pay.payload_valid & pay.payload_bit;
                if (strobe_rise && !pay.payload_valid) underrun_d = 1'b1;
            end
            TRAIN: begin
                base   = OFF_T;
                len_m1 = 8'(TSC_LEN - 1);
                b      = tsc_sh[TSC_LEN-1];
            end
            END_TAIL: begin
                base   = OFF_E;
                len_m1 = 8'(TAIL_LEN - 1);
            end
            GUARD: begin
                base   = OFF_G;
                len_m1 = 8'(GUARD_LEN - 1);
                b      = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (strobe_rise && state_q != IDLE) begin
            sym_index_d = base + cnt_q;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
            current_symbol_d = (state_q == GUARD) ? 1'b1 : (b ^ prev_sym_q);
            prev_sym_d       = b;
`else
            current_symbol_d = b;
`endif
            if (cnt_q == len_m1) begin
                cnt_d   = 8'd0;
                state_d = next_state(state_q);
                if (state_q == GUARD) begin
                    busy_d       = 1'b0;
                    burst_done_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= 8'd0;
            current_symbol_q <= 1'b1;
            sym_index_q      <= 8'd0;
            busy_q           <= 1'b0;
            burst_done_q     <= 1'b0;
            underrun_q       <= 1'b0;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
            prev_sym_q       <= 1'b1;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            current_symbol_q <= current_symbol_d;
            sym_index_q      <= sym_index_d;
            busy_q           <= busy_d;
            burst_done_q     <= burst_done_d;
            underrun_q       <= underrun_d;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
            prev_sym_q       <= prev_sym_d;
`endif
        end
    end

    assign current_symbol = current_symbol_q;
    assign sym_index      = sym_index_q;
    assign busy           = busy_q;
    assign burst_done     = burst_done_q;
    assign underrun       = underrun_q;
endmodule

// File: tb/tb_burst_formatter.sv
// Directed bench for burst_formatter; expected symbols come from the
// burst layout by index (diff-encoded when the macro is defined).
module tb_burst_formatter;
    import burst_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       strobe;
    logic       fire;
    logic       cur_sym;
    logic [7:0] idx;
    logic       busy;
    logic       done;
    logic       under;

    int errors = 0;
    int checks = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;

    localparam logic [25:0] TSC_V = 26'h0970897;

    burst_formatter_if pay ();

    burst_formatter dut (
        .clock              (clk),
        .reset              (rst_n),
        .next_symbol_strobe (strobe),
        .fire_burst         (fire),
        .pay                (pay.slave),
        .current_symbol     (cur_sym),
        .sym_index          (idx),
        .busy               (busy),
        .burst_done         (done),
        .underrun           (under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pay.payload_ready) rdy_cnt <= rdy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cur_sym !== 1'b1) begin
            errors++;
            $display("FAIL reset_sym got=%b exp=1", cur_sym);
        end
        checks++;
        if (idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_idx got=%0d exp=0", idx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (under !== 1'b0) begin
            errors++;
            $display("FAIL reset_underrun got=%b exp=0", under);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives one complete burst and checks every emitted symbol.
    task automatic burst_scenario(input string nm, input int hi,
                                  input int gap, input int dlo,
                                  input int dhi, input bit ones,
                                  input bit fire_mid, input bit fired);
        int   r0, d0, j;
        logic raw, exp_s, prev;
        logic [25:0] tv;
        tv = TSC_V;
        if (!fired) begin
            fire = 1'b1;
            @(posedge clk);
            #1;
            fire = 1'b0;
            checks++;
            if (busy !== 1'b1 || under !== 1'b0 || cur_sym !== 1'b1) begin
                errors++;
                $display("FAIL %s_fire busy=%b und=%b sym=%b exp 1,0,1",
                         nm, busy, under, cur_sym);
            end
        end
        r0 = rdy_cnt;
        d0 = done_cnt;
        prev = 1'b1;
        for (int k = 0; k < BURST_SYMBOLS; k++) begin
            j = -1;
            if (k >= 3 && k < 61) j = k - 3;
            else if (k >= 87 && k < 145) j = k - 29;
            pay.payload_bit   = 1'b1;
            pay.payload_valid = 1'b1;
            if (j >= 0) begin
                pay.payload_bit   = ones ? 1'b1 : ~j[0];
                pay.payload_valid = !(j >= dlo && j <= dhi);
            end
            if (k < 3) raw = 1'b0;
            else if (k < 61) raw = pay.payload_bit & pay.payload_valid;
            else if (k < 87) raw = tv[25-(k-61)];
            else if (k < 145) raw = pay.payload_bit & pay.payload_valid;
            else if (k < 148) raw = 1'b0;
            else raw = 1'b1;
`ifdef BURST_FORMATTER_DIFF_ENCODE_EN
            exp_s = (k >= 148) ? 1'b1 : (raw ^ prev);
            prev  = raw;
`else
            exp_s = raw;
`endif
            strobe = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (cur_sym !== exp_s || idx !== 8'(k)) begin
                errors++;
                $display("FAIL %s_sym k=%0d got sym=%b idx=%0d exp sym=%b",
                         nm, k, cur_sym, idx, exp_s);
            end
            checks++;
            if (busy !== (k < 155) || done !== (k == 155)) begin
                errors++;
                $display("FAIL %s_flags k=%0d busy=%b done=%b", nm, k,
                         busy, done);
            end
            for (int h = 1; h < hi; h++) begin
                @(posedge clk);
                #1;
                checks++;
                if (cur_sym !== exp_s || done !== 1'b0 ||
                    (k < 155 && idx !== 8'(k))) begin
                    errors++;
                    $display("FAIL %s_hold k=%0d sym=%b idx=%0d done=%b",
                             nm, k, cur_sym, idx, done);
                end
            end
            strobe = 1'b0;
            if (fire_mid && k == 80) fire = 1'b1;
            repeat (gap) begin
                @(posedge clk);
                #1;
                fire = 1'b0;
            end
        end
        checks++;
        if (rdy_cnt - r0 != 116) begin
            errors++;
            $display("FAIL %s_ready got=%0d exp=116", nm, rdy_cnt - r0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done_pulses got=%0d exp=1", nm, done_cnt - d0);
        end
        checks++;
        if (under !== (dlo <= dhi)) begin
            errors++;
            $display("FAIL %s_underrun got=%b exp=%b", nm, under, dlo <= dhi);
        end
        checks++;
        if (busy !== 1'b0 || idx !== 8'd0 || cur_sym !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle busy=%b idx=%0d sym=%b", nm, busy, idx,
                     cur_sym);
        end
    endtask

    task automatic test_basic_burst;
        burst_scenario("basic", 2, 46, 1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_long_strobe;
        burst_scenario("long", 10, 2, 1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_underrun;
        burst_scenario("under", 2, 3, 10, 12, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (under !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky got=%b exp=1", under);
        end
    endtask

    task automatic test_fire_mid_burst;
        int r0;
        burst_scenario("firemid", 2, 3, 1, 0, 1'b0, 1'b1, 1'b0);
        r0 = rdy_cnt;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rdy_cnt != r0) begin
            errors++;
            $display("FAIL firemid_after busy=%b ready=%0d exp 0,0", busy,
                     rdy_cnt - r0);
        end
    endtask

    task automatic test_fire_coincident;
        fire   = 1'b1;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        fire = 1'b0;
        checks++;
        if (busy !== 1'b1 || cur_sym !== 1'b1 || idx !== 8'd0) begin
            errors++;
            $display("FAIL coinc_fire busy=%b sym=%b idx=%0d exp 1,1,0",
                     busy, cur_sym, idx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cur_sym !== 1'b1 || idx !== 8'd0) begin
            errors++;
            $display("FAIL coinc_hold sym=%b idx=%0d exp 1,0", cur_sym, idx);
        end
        strobe = 1'b0;
        @(posedge clk);
        #1;
        burst_scenario("coinc", 2, 3, 1, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_diff_encode;
        burst_scenario("ones", 2, 3, 1, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_burst;
        int r0;
        fire = 1'b1;
        @(posedge clk);
        #1;
        fire = 1'b0;
        pay.payload_bit   = 1'b1;
        pay.payload_valid = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            strobe = 1'b1;
            @(posedge clk);
            #1;
            strobe = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (idx !== 8'd70) begin
            errors++;
            $display("FAIL rstmid_pre idx=%0d exp=70", idx);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (cur_sym !== 1'b1 || busy !== 1'b0 || idx !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_state sym=%b busy=%b idx=%0d exp 1,0,0",
                     cur_sym, busy, idx);
        end
        r0 = rdy_cnt;
        for (int k = 0; k < 5; k++) begin
            strobe = 1'b1;
            @(posedge clk);
            #1;
            strobe = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (rdy_cnt != r0 || busy !== 1'b0 || idx !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_idle ready=%0d busy=%b idx=%0d exp 0,0,0",
                     rdy_cnt - r0, busy, idx);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        strobe            = 1'b0;
        fire              = 1'b0;
        pay.payload_bit   = 1'b0;
        pay.payload_valid = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_burst();
        test_long_strobe();
        test_underrun();
        test_fire_mid_burst();
        test_fire_coincident();
        test_diff_encode();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
